// File: rtl/sdarb_pkg.sv
// Shared types and address packing for the SDRAM request scheduler.
package sdarb_pkg;

    localparam int unsigned BA_W   = 2;
    localparam int unsigned ROW_W  = 12;
    localparam int unsigned COL_W  = 8;
    localparam int unsigned ADDR_W = BA_W + ROW_W + COL_W;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_BUSY,
        RD_REQ,
        RD_BUSY
    } state_t;

    // Every burst starts at column 0 of its row.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [BA_W-1:0]  bank,
                                                    input logic [ROW_W-1:0] row);
        return {bank, row, COL_W'(0)};
    endfunction

endpackage

// File: rtl/sdram_arb_burst_addr_gen.sv
// Per-side burst row counter with deferred frame restart and end-of-frame wrap/hold.
module burst_addr_gen
    import sdarb_pkg::*;
#(
    parameter int unsigned FRAME_BURSTS = 480,
    parameter bit          WRAP         = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             busy,
    input  logic             done,
    output logic [ROW_W-1:0] row,
    output logic             apply_c
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_BURSTS - 1);

    logic pend;

    // A frame restart takes effect now when idle, otherwise at the end of the running burst.
    assign apply_c = done ? (pend | frame_start) : (frame_start & ~busy);

    always_ff @(posedge clk) begin
        if (rst) begin
            row  <= '0;
            pend <= 1'b0;
        end else if (done) begin
            pend <= 1'b0;
            if (pend | frame_start) begin
                row <= '0;
            end else if (row == LAST_ROW) begin
                row <= WRAP ? '0 : LAST_ROW;
            end else begin
                row <= row + ROW_W'(1);
            end
        end else if (frame_start) begin
            if (busy) begin
                pend <= 1'b1;
            end else begin
                row <= '0;
            end
        end
    end

endmodule

// File: rtl/sdram_arb.sv
// Write/read burst scheduler between capture/display FIFOs and the SDRAM controller.
// Optional double buffering via SDARB_PINGPONG_EN.
module sdram_arb
    import sdarb_pkg::*;
#(
    parameter int unsigned BURST        = 160,
    parameter int unsigned FRAME_BURSTS = 480,
    parameter int unsigned UW           = 10,
    parameter int unsigned RD_LOW       = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [UW-1:0]     wrf_usedw,
    input  logic [UW-1:0]     rdf_usedw,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sys_wraddr,
    output logic [ADDR_W-1:0] sys_rdaddr,
    output logic              wr_overrun
);

    state_t           state, state_n;
    logic             wr_ack_d, rd_ack_d;
    logic             last_wr, rd_valid;
    logic             wr_want, rd_want;
    logic             wr_done, rd_done;
    logic             wr_apply, rd_apply;
    logic [ROW_W-1:0] wr_row, rd_row;
    logic [BA_W-1:0]  wr_bank, rd_bank;

    assign wr_want = wrf_usedw >= UW'(BURST);
    assign rd_want = (rdf_usedw <= UW'(RD_LOW)) && rd_valid;

    burst_addr_gen #(.FRAME_BURSTS(FRAME_BURSTS), .WRAP(1'b0)) u_wr_gen (
        .clk         (clk),
        .rst         (rst),
        .frame_start (wr_frame_start),
        .busy        ((state == WR_REQ) || (state == WR_BUSY)),
        .done        (wr_done),
        .row         (wr_row),
        .apply_c     (wr_apply)
    );

    burst_addr_gen #(.FRAME_BURSTS(FRAME_BURSTS), .WRAP(1'b1)) u_rd_gen (
        .clk         (clk),
        .rst         (rst),
        .frame_start (rd_frame_start),
        .busy        ((state == RD_REQ) || (state == RD_BUSY)),
        .done        (rd_done),
        .row         (rd_row),
        .apply_c     (rd_apply)
    );

    // Row and bank only move at burst end, so the address stays stable across a burst.
    assign sys_wraddr = pack_addr(wr_bank, wr_row);
    assign sys_rdaddr = pack_addr(rd_bank, rd_row);

    // Next-state: wants are looked at only in IDLE; ties go to the side not served last.
    always_comb begin
        state_n = state;
        wr_done = 1'b0;
        rd_done = 1'b0;
        case (state)
            IDLE: begin
                if (wr_want && (!rd_want || !last_wr)) begin
                    state_n = WR_REQ;
                end else if (rd_want) begin
                    state_n = RD_REQ;
                end
            end
            WR_REQ:  if (sdram_wr_ack) state_n = WR_BUSY;
            WR_BUSY: begin
                if (wr_ack_d && !sdram_wr_ack) begin
                    wr_done = 1'b1;
                    state_n = IDLE;
                end
            end
            RD_REQ:  if (sdram_rd_ack) state_n = RD_BUSY;
            RD_BUSY: begin
                if (rd_ack_d && !sdram_rd_ack) begin
                    rd_done = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
            wr_ack_d     <= 1'b0;
            rd_ack_d     <= 1'b0;
            last_wr      <= 1'b0;
            wr_overrun   <= 1'b0;
        end else begin
            state        <= state_n;
            sdram_wr_req <= (state_n == WR_REQ);
            sdram_rd_req <= (state_n == RD_REQ);
            wr_ack_d     <= sdram_wr_ack;
            rd_ack_d     <= sdram_rd_ack;
            if (state == IDLE && state_n == WR_REQ) last_wr <= 1'b1;
            if (state == IDLE && state_n == RD_REQ) last_wr <= 1'b0;
            if (wrf_usedw == '1) wr_overrun <= 1'b1;
        end
    end

`ifdef SDARB_PINGPONG_EN
    logic [BA_W-1:0] ready_bank;

    // Writer flips buffers per frame; reader picks up the last completed one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank    <= '0;
            rd_bank    <= '0;
            ready_bank <= '0;
            rd_valid   <= 1'b0;
        end else begin
            if (wr_apply) begin
                wr_bank    <= BA_W'(!wr_bank[0]);
                ready_bank <= wr_bank;
                rd_valid   <= 1'b1;
            end
            if (rd_apply) rd_bank <= ready_bank;
        end
    end
`else
    logic unused_apply;

    assign wr_bank      = '0;
    assign rd_bank      = '0;
    assign unused_apply = wr_apply ^ rd_apply;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else if (wr_frame_start) begin
            rd_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_arb.sv
// Directed self-checking bench for sdram_arb (both SDARB_PINGPONG_EN builds).
module tb_sdram_arb;

`ifdef SDARB_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  wrf_usedw = '0;
    logic [9:0]  rdf_usedw = '0;
    logic        wr_frame_start = 1'b0;
    logic        rd_frame_start = 1'b0;
    logic        sdram_wr_ack = 1'b0;
    logic        sdram_rd_ack = 1'b0;
    logic        sdram_wr_req, sdram_rd_req, wr_overrun;
    logic [21:0] sys_wraddr, sys_rdaddr;

    int total = 0;
    int bad   = 0;

    sdram_arb dut (
        .clk            (clk),
        .rst            (rst),
        .wrf_usedw      (wrf_usedw),
        .rdf_usedw      (rdf_usedw),
        .wr_frame_start (wr_frame_start),
        .rd_frame_start (rd_frame_start),
        .sdram_wr_ack   (sdram_wr_ack),
        .sdram_rd_ack   (sdram_rd_ack),
        .sdram_wr_req   (sdram_wr_req),
        .sdram_rd_req   (sdram_rd_req),
        .sys_wraddr     (sys_wraddr),
        .sys_rdaddr     (sys_rdaddr),
        .wr_overrun     (wr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // g: 1 = write request seen, 2 = read request seen, 0 = none within budget
    task automatic grant(output int g);
        g = 0;
        for (int i = 0; i < 20; i++) begin
            if (sdram_wr_req) begin g = 1; break; end
            if (sdram_rd_req) begin g = 2; break; end
            step(1);
        end
    endtask

    task automatic ack_burst(input bit is_wr, input int n);
        if (is_wr) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
        step(n);
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        step(1);
    endtask

    task automatic burst(input bit is_wr, input int n, input string tag);
        int g;
        grant(g);
        chk(tag, 32'(g), is_wr ? 32'd1 : 32'd2);
        ack_burst(is_wr, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        wrf_usedw = '0;
        rdf_usedw = 10'd300;
        step(2);
        rst = 1'b0;
    endtask

    task automatic pulse_wr_frame();
        wr_frame_start = 1'b1;
        step(1);
        wr_frame_start = 1'b0;
    endtask

    initial begin
        int g;

        // First write burst after reset
        step(3);
        chk("rst_wr_req", 32'(sdram_wr_req), 32'd0);
        chk("rst_rd_req", 32'(sdram_rd_req), 32'd0);
        chk("rst_wraddr", 32'(sys_wraddr), 32'd0);
        chk("rst_rdaddr", 32'(sys_rdaddr), 32'd0);
        chk("rst_overrun", 32'(wr_overrun), 32'd0);
        rst = 1'b0;
        wrf_usedw = 10'd160;
        rdf_usedw = 10'd0;
        step(1);
        chk("wr_req_latency", 32'(sdram_wr_req), 32'd1);
        chk("rd_req_first", 32'(sdram_rd_req), 32'd0);
        sdram_wr_ack = 1'b1;
        wrf_usedw = 10'd0;
        step(1);
        chk("wr_req_drop", 32'(sdram_wr_req), 32'd0);
        chk("wraddr_in_burst", 32'(sys_wraddr), 32'd0);
        step(159);
        sdram_wr_ack = 1'b0;
        step(1);
        chk("wraddr_after_1", 32'(sys_wraddr), 32'h000100);
        step(3);
        chk("rd_invalid_no_req", 32'(sdram_rd_req), 32'd0);
        chk("wr_idle_no_req", 32'(sdram_wr_req), 32'd0);

        // Round-robin alternation once reads are valid
        do_reset();
        pulse_wr_frame();
        wrf_usedw = 10'd200;
        rdf_usedw = 10'd100;
        for (int i = 0; i < 6; i++) burst((i % 2) == 0, 2, "rr_grant");
        wrf_usedw = 10'd0;
        rdf_usedw = 10'd300;
        step(2);
        chk("rr_wraddr", 32'(sys_wraddr), PP ? 32'h100300 : 32'h000300);
        chk("rr_rdaddr", 32'(sys_rdaddr), 32'h000300);

        // Write row holds at the last row of the frame
        do_reset();
        wrf_usedw = 10'd200;
        for (int i = 0; i < 481; i++) burst(1'b1, 1, "fill_grant");
        wrf_usedw = 10'd0;
        step(2);
        chk("hold_row", 32'(sys_wraddr[19:8]), 32'd479);
        chk("hold_addr", 32'(sys_wraddr), 32'h01DF00);
        pulse_wr_frame();
        chk("frame_restart", 32'(sys_wraddr), PP ? 32'h100000 : 32'h000000);

        // Frame restart arriving mid-burst is deferred to burst end
        wrf_usedw = 10'd200;
        burst(1'b1, 1, "pre_grant");
        grant(g);
        chk("mid_grant", 32'(g), 32'd1);
        chk("mid_addr_req", 32'(sys_wraddr), PP ? 32'h100100 : 32'h000100);
        sdram_wr_ack = 1'b1;
        step(1);
        wr_frame_start = 1'b1;
        step(1);
        wr_frame_start = 1'b0;
        chk("mid_addr_busy", 32'(sys_wraddr), PP ? 32'h100100 : 32'h000100);
        step(1);
        sdram_wr_ack = 1'b0;
        step(1);
        chk("mid_addr_after", 32'(sys_wraddr), 32'h000000);
        grant(g);
        chk("next_grant", 32'(g), 32'd1);
        chk("next_addr", 32'(sys_wraddr), 32'h000000);
        wrf_usedw = 10'd0;
        ack_burst(1'b1, 1);

        // Read row wraps to 0 after the last row
        rdf_usedw = 10'd100;
        for (int i = 0; i < 480; i++) begin
            if (i == 479) chk("rd_last_row", 32'(sys_rdaddr), 32'h01DF00);
            burst(1'b0, 1, "rd_grant");
        end
        rdf_usedw = 10'd300;
        step(1);
        chk("rd_wrap", 32'(sys_rdaddr), 32'h000000);

        // Overrun is sticky; reset mid-burst clears every output
        wrf_usedw = 10'd1023;
        step(1);
        chk("overrun_set", 32'(wr_overrun), 32'd1);
        wrf_usedw = 10'd0;
        ack_burst(1'b1, 1);
        step(2);
        chk("overrun_sticky", 32'(wr_overrun), 32'd1);
        chk("wraddr_pre_rst", 32'(sys_wraddr), 32'h000200);
        rdf_usedw = 10'd100;
        grant(g);
        chk("rd_busy_grant", 32'(g), 32'd2);
        sdram_rd_ack = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        chk("rst_mid_rd_req", 32'(sdram_rd_req), 32'd0);
        chk("rst_mid_wr_req", 32'(sdram_wr_req), 32'd0);
        chk("rst_mid_wraddr", 32'(sys_wraddr), 32'd0);
        chk("rst_mid_rdaddr", 32'(sys_rdaddr), 32'd0);
        chk("rst_mid_overrun", 32'(wr_overrun), 32'd0);
        sdram_rd_ack = 1'b0;
        rst = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdram_arb.md
# sdram_arb

Request scheduler between the capture write FIFO, the display read FIFO and the SDRAM controller in the video capture path. Decides which FIFO gets the next SDRAM burst, drives the request/acknowledge handshake and generates burst addresses. With the optional ping-pong feature, it manages two frame buffers so display never reads a frame still being written. Runs in the 100 MHz SDRAM clock domain.

## Interface
- BURST, 160, words per SDRAM burst; must equal `sdwr_byte`/`sdrd_byte`
- FRAME_BURSTS, 480, bursts per frame (320x240 / 160)
- UW, 10, width of FIFO fill-level inputs
- RD_LOW, 256, read-FIFO fill level at or below which a read burst is wanted
- clk  in  1  SDRAM-domain clock (100 MHz)
- rst  in  1  synchronous reset, active-high
- wrf_usedw  in  UW  write-FIFO fill level (read side)
- rdf_usedw  in  UW  read-FIFO fill level (write side)
- wr_frame_start  in  1  one-cycle pulse, new capture frame; already synchronised to clk
- rd_frame_start  in  1  one-cycle pulse, new display frame; already synchronised to clk
- sdram_wr_ack  in  1  high while controller transfers write-burst data
- sdram_rd_ack  in  1  high while controller transfers read-burst data
- sdram_wr_req  out  1  write-burst request
- sdram_rd_req  out  1  read-burst request
- sys_wraddr  out  22  {bank[21:20], row[19:8], col[7:0]}; col always 0
- sys_rdaddr  out  22  same format
- wr_overrun  out  1  sticky; set when wrf_usedw reaches 2^UW-1; cleared by rst

## Operation
- States: IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY.
- wr_want = wrf_usedw >= BURST. rd_want = (rdf_usedw <= RD_LOW) && rd_valid.
- rd_valid is cleared by rst. It is set by the first completed write frame.
- IDLE: if only one want is set, grant that side. If both are set, grant the side not served last (round-robin bit `last_wr`). After reset, `last_wr`=0, so write wins the first tie.
- X_REQ: hold req high. When ack=1, go to X_BUSY and drop req in the same transition.
- X_BUSY: on the ack falling edge (registered ack_d=1, ack=0), advance that side's row, then go to IDLE.
- Row counter: each burst occupies one row, starting at col 0. The row counts 0..FRAME_BURSTS-1. After FRAME_BURSTS-1 it holds at FRAME_BURSTS-1 (write) or wraps to 0 (read).
- wr_frame_start: the write row is set to 0. If the pulse arrives in WR_REQ or WR_BUSY, it is latched as pending and applied when the burst completes, after that burst's row increment would have applied. The frame that just ended is marked complete.
- rd_frame_start: the read row is set to 0, with the same deferral rule in RD_REQ or RD_BUSY.
- Address: bank = wr_bank (write) or rd_bank (read); row = counter; col = 8'd0.
- Addresses are registered and stable from req assertion until the burst ends.

## Timing
- Reset values: sdram_wr_req=0, sdram_rd_req=0, sys_wraddr=0, sys_rdaddr=0, wr_overrun=0, state=IDLE, rows=0, wr_bank=0, rd_bank=0, rd_valid=0.
- IDLE with a want set: req goes high on the next clk edge (1-cycle latency).
- Req falls on the edge after ack is first sampled high.
- Next grant is decided in the IDLE cycle following the ack fall. Minimum gap between bursts is 2 cycles.
- Want conditions are evaluated only in IDLE. Level changes during a burst have no effect until IDLE.
- rst mid-burst: outputs return to reset values immediately. The SDRAM controller is reset from the same source.

## Configuration
- SDARB_PINGPONG_EN defined:
  - Two frame buffers, bank 0 and bank 1.
  - On wr_frame_start (applied), wr_bank toggles and the completed bank becomes `ready_bank`.
  - On rd_frame_start (applied), rd_bank takes `ready_bank`.
  - rd_valid is set on the first write-frame completion.
- SDARB_PINGPONG_EN undefined:
  - wr_bank = rd_bank = 0 at all times.
  - rd_valid is set on the first wr_frame_start.
  - Display may show a torn frame.

## Structure
- Shared package `sdarb_pkg`: state enum; address field widths (BA_W=2, ROW_W=12, COL_W=8); a function packing {bank,row,col} into 22 bits.
- One sub-module, `burst_addr_gen`, instantiated twice (write and read). It holds the row counter, the pending-frame-reset latch and the wrap/hold rule, selected by a WRAP parameter.
- Arbiter FSM and round-robin bit stay in the top module.

## Test plan
- After reset, wrf_usedw=160 and rdf_usedw=0: wr_req rises 1 cycle later. Ack pulses high for 160 cycles. After the ack falls, the next write address is 22'h000100 and rd_req stays 0, because rd_valid=0.
- After one wr_frame_start, wrf_usedw=200 and rdf_usedw=100 simultaneously: grants alternate, first WR after reset, then RD, then WR. Verified over 6 bursts.
- 480 write bursts without a frame pulse: row holds at 479 (sys_wraddr row field = 12'd479). Then wr_frame_start gives row 0, and with PINGPONG the bank becomes 1.
- wr_frame_start asserted mid-WR_BUSY: the current burst completes at its original address. The next write burst uses row 0.
- Reader at row 479 completes a burst: the read row wraps to 0 in the same bank (no rd_frame_start).
- wrf_usedw=1023: wr_overrun=1 and stays 1 after the level drops. rst asserted mid-RD_BUSY: all outputs are 0 on the next cycle.
